mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage between regM and regW. Turns load/store control from regM into
//  one valid/ready data-bus transaction; aligns and extends load data into memory_o_memdata
//  (feeds regW memory_i_memdata). Holds regM and earlier stages with memory_o_stall until done.
//  Glue forces regW commit/reg_wen to 0 on stalled cycles; regW itself is unchanged.
// PARAMETERS
//  TIMEOUT  255  max WAIT-state cycles before bus error; 0 = no timeout
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-low
//  regM_i_valid        in   1   regM holds a live instruction
//  regM_i_mem_ren      in   1   load
//  regM_i_mem_wen      in   1   store (ren and wen never both 1)
//  regM_i_mem_size     in   2   0 byte, 1 half, 2 word, 3 dword
//  regM_i_mem_unsigned in   1   zero-extend load (else sign-extend)
//  regM_i_alu_result   in   64  effective address
//  regM_i_store_data   in   64  rs2 value, data in low bits
//  dmem_req_valid      out  1   request valid
//  dmem_req_ready      in   1   bus accepts request
//  dmem_req_addr       out  64  {addr[63:3],3'b0}
//  dmem_req_wen        out  1   1 = write
//  dmem_req_wdata      out  64  store data shifted to byte lane
//  dmem_req_wstrb      out  8   byte enables (0 for reads)
//  dmem_resp_valid     in   1   response/ack, one cycle per request
//  dmem_resp_rdata     in   64  aligned doubleword read data
//  memory_o_memdata    out  64  extended load result to regW
//  memory_o_stall      out  1   hold regM and upstream
//  memory_o_misalign   out  1   1-cycle pulse: misaligned access, no bus request
//  memory_o_bus_err    out  1   1-cycle pulse in DONE after a timeout
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, data_q=0, timeout cnt=0, err_q=0. While rst==0,
//   dmem_req_valid, memory_o_stall, misalign and bus_err are 0 and memdata is 0.
//  mem_op = regM_i_valid & (ren|wen). off = addr[2:0].
//  Misaligned: half & off[0]; word & off[1:0]!=0; dword & off!=0.
//  IDLE: mem_op aligned -> stall=1, latch addr/size/unsigned/wen/wdata/wstrb -> REQ.
//   mem_op misaligned -> misalign=1, stall=0, memdata=0, stay IDLE.
//   No mem_op -> stall=0, memdata=0. resp_valid in IDLE is ignored.
//  REQ: req_valid=1, stall=1, request fields stable from latches; valid not dropped before
//   ready. On ready -> WAIT, cnt=0.
//  WAIT: stall=1. resp_valid -> load: data_q=extend(rdata>>(off*8)), store: data_q=0 -> DONE.
//   Else cnt++. If TIMEOUT!=0 and cnt==TIMEOUT-1 -> data_q=0, err_q=1 -> DONE.
//   A response arriving after a timeout is ignored.
//  DONE: stall=0, memdata=data_q, bus_err=err_q. regW and regM both capture at this edge.
//   Next state IDLE; err_q cleared.
//  Min mem-op latency, ready=1 and response 1 cycle after handshake: 4 cycles, stall high 3.
//  Response never in the same cycle as handshake; WAIT always lasts at least 1 cycle.
//  wstrb: byte 8'h01<<off, half 8'h03<<off, word 8'h0F<<off, dword 8'hFF.
//  wdata = store_data<<(off*8), truncated to 64 bits.
//  Load extend: byte/half/word from bit 7/15/31 of the shifted data; 0-fill if unsigned.
//  Mid-operation reset: back to IDLE next cycle, request abandoned; stale response dropped.
// TESTING
//  lb addr 0x1003, rdata 0x80_0000_0000_0000_00FF<<24 style lane 3 = 0x80 ->
//   memdata 0xFFFF_FFFF_FFFF_FF80; lbu same -> 0x80.
//  sh addr 0x2006, store_data 0x1234 -> wstrb 0xC0, wdata[63:48]=0x1234, req_addr 0x2000.
//  lw addr 0x3002 -> misalign pulse 1 cycle, req_valid never asserted, stall 0.
//  ld with ready low 5 cycles, resp 3 cycles later -> stall high 10 cycles, memdata in DONE.
//  TIMEOUT=4, ld, no response -> bus_err pulse in DONE, memdata 0; later resp ignored.
//  rst low while in WAIT -> next cycle IDLE, stall 0; late resp_valid has no effect.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus link between the memory-access stage and the data memory:
// a valid/ready request channel plus a one-cycle response/ack channel.
interface mem_access_if;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_req_addr;
   logic        dmem_req_wen;
   logic [63:0] dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_rdata;

   modport master (
      output dmem_req_valid,
      input  dmem_req_ready,
      output dmem_req_addr,
      output dmem_req_wen,
      output dmem_req_wdata,
      output dmem_req_wstrb,
      input  dmem_resp_valid,
      input  dmem_resp_rdata
   );

   modport slave (
      input  dmem_req_valid,
      output dmem_req_ready,
      input  dmem_req_addr,
      input  dmem_req_wen,
      input  dmem_req_wdata,
      input  dmem_req_wstrb,
      output dmem_resp_valid,
      output dmem_resp_rdata
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: converts regM load/store control into one data-bus
// transaction, stalls upstream until done and returns the extended load result.
module mem_access #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         regM_i_valid,
   input  logic         regM_i_mem_ren,
   input  logic         regM_i_mem_wen,
   input  logic [1:0]   regM_i_mem_size,
   input  logic         regM_i_mem_unsigned,
   input  logic [63:0]  regM_i_alu_result,
   input  logic [63:0]  regM_i_store_data,
   mem_access_if.master dmem,
   output logic [63:0]  memory_o_memdata,
   output logic         memory_o_stall,
   output logic         memory_o_misalign,
   output logic         memory_o_bus_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit HAS_TIMEOUT = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t           state_reg;
   logic [63:0]      addr_reg;
   logic [1:0]       size_reg;
   logic             unsigned_reg;
   logic             wen_reg;
   logic [63:0]      wdata_reg;
   logic [7:0]       wstrb_reg;
   logic [63:0]      data_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             err_reg;

   logic        mem_op;
   logic [2:0]  off;
   logic        misaligned;
   logic [3:0]  nbytes;
   logic [7:0]  lane_en;
   logic [7:0]  wstrb_next;
   logic [63:0] wdata_next;
   logic [63:0] rdata_shifted;
   logic [63:0] load_next;

   assign mem_op = regM_i_valid & (regM_i_mem_ren | regM_i_mem_wen);
   assign off    = regM_i_alu_result[2:0];
   assign nbytes = 4'd1 << regM_i_mem_size;

   always_comb begin
      misaligned = 1'b0;
      case (regM_i_mem_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = off[0];
         2'd2:    misaligned = (off[1:0] != 2'b00);
         default: misaligned = (off != 3'b000);
      endcase
   end

   // A byte lane is enabled when it falls inside [off, off + access size).
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign lane_en[gi] = (4'(gi) >= {1'b0, off}) && (4'(gi) < ({1'b0, off} + nbytes));
      end
   endgenerate

   assign wstrb_next = regM_i_mem_wen ? lane_en : 8'h00;
   assign wdata_next = regM_i_mem_wen ? (regM_i_store_data << {off, 3'b000}) : 64'd0;

   assign rdata_shifted = dmem.dmem_resp_rdata >> {addr_reg[2:0], 3'b000};

   always_comb begin
      load_next = rdata_shifted;
      case (size_reg)
         2'd0: load_next = unsigned_reg ? {56'd0, rdata_shifted[7:0]}
                                        : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'd1: load_next = unsigned_reg ? {48'd0, rdata_shifted[15:0]}
                                        : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
         2'd2: load_next = unsigned_reg ? {32'd0, rdata_shifted[31:0]}
                                        : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
         default: load_next = rdata_shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= 64'd0;
         size_reg     <= 2'd0;
         unsigned_reg <= 1'b0;
         wen_reg      <= 1'b0;
         wdata_reg    <= 64'd0;
         wstrb_reg    <= 8'h00;
         data_reg     <= 64'd0;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (mem_op && !misaligned) begin
                  addr_reg     <= regM_i_alu_result;
                  size_reg     <= regM_i_mem_size;
                  unsigned_reg <= regM_i_mem_unsigned;
                  wen_reg      <= regM_i_mem_wen;
                  wdata_reg    <= wdata_next;
                  wstrb_reg    <= wstrb_next;
                  state_reg    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (dmem.dmem_req_ready) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem.dmem_resp_valid) begin
                  data_reg  <= wen_reg ? 64'd0 : load_next;
                  state_reg <= ST_DONE;
               end else if (HAS_TIMEOUT && (cnt_reg == CNT_LAST)) begin
                  data_reg  <= 64'd0;
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               err_reg   <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Request fields come only from the latches so they stay stable until accepted.
   assign dmem.dmem_req_valid = rst && (state_reg == ST_REQ);
   assign dmem.dmem_req_addr  = {addr_reg[63:3], 3'b000};
   assign dmem.dmem_req_wen   = wen_reg;
   assign dmem.dmem_req_wdata = wdata_reg;
   assign dmem.dmem_req_wstrb = wstrb_reg;

   assign memory_o_stall    = rst && (((state_reg == ST_IDLE) && mem_op && !misaligned) ||
                                      (state_reg == ST_REQ) || (state_reg == ST_WAIT));
   assign memory_o_misalign = rst && (state_reg == ST_IDLE) && mem_op && misaligned;
   assign memory_o_memdata  = (rst && (state_reg == ST_DONE)) ? data_reg : 64'd0;
   assign memory_o_bus_err  = rst && (state_reg == ST_DONE) && err_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard queues of expected requests and
// results, checked with immediate assertions when the DUT produces them.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        regM_i_valid;
   logic        regM_i_mem_ren;
   logic        regM_i_mem_wen;
   logic [1:0]  regM_i_mem_size;
   logic        regM_i_mem_unsigned;
   logic [63:0] regM_i_alu_result;
   logic [63:0] regM_i_store_data;
   logic [63:0] memory_o_memdata;
   logic        memory_o_stall;
   logic        memory_o_misalign;
   logic        memory_o_bus_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } req_t;

   typedef struct {
      logic [63:0] memdata;
      logic        bus_err;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];

   always #5 clk = ~clk;

   mem_access_if bus ();

   mem_access #(.TIMEOUT(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .regM_i_valid        (regM_i_valid),
      .regM_i_mem_ren      (regM_i_mem_ren),
      .regM_i_mem_wen      (regM_i_mem_wen),
      .regM_i_mem_size     (regM_i_mem_size),
      .regM_i_mem_unsigned (regM_i_mem_unsigned),
      .regM_i_alu_result   (regM_i_alu_result),
      .regM_i_store_data   (regM_i_store_data),
      .dmem                (bus),
      .memory_o_memdata    (memory_o_memdata),
      .memory_o_stall      (memory_o_stall),
      .memory_o_misalign   (memory_o_misalign),
      .memory_o_bus_err    (memory_o_bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference load: gather bytes starting at the offset, then sign/zero fill.
   function automatic logic [63:0] load_model(input logic [1:0] size, input bit uns,
                                               input int off, input logic [63:0] rdata);
      logic [63:0] r;
      int n;
      r = 64'd0;
      n = 1 << size;
      for (int i = 0; i < n; i++) r[i*8 +: 8] = rdata[(off+i)*8 +: 8];
      if (!uns && n < 8 && r[n*8-1]) begin
         for (int j = n*8; j < 64; j++) r[j] = 1'b1;
      end
      return r;
   endfunction

   task automatic issue(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                        input logic [63:0] addr, input logic [63:0] sdata);
      regM_i_valid        = 1'b1;
      regM_i_mem_ren      = ld;
      regM_i_mem_wen      = st;
      regM_i_mem_size     = size;
      regM_i_mem_unsigned = uns;
      regM_i_alu_result   = addr;
      regM_i_store_data   = sdata;
   endtask

   task automatic push_req(input logic [63:0] addr, input logic wen,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
      req_t r;
      r.addr = addr; r.wen = wen; r.wdata = wdata; r.wstrb = wstrb;
      req_q.push_back(r);
   endtask

   task automatic push_res(input logic [63:0] memdata, input logic bus_err);
      res_t e;
      e.memdata = memdata; e.bus_err = bus_err;
      res_q.push_back(e);
   endtask

   // Runs one already-issued aligned op through REQ/WAIT/DONE and checks it.
   task automatic run_op(input int ready_delay, input int resp_delay, input bit respond,
                         input logic [63:0] rdata, input int exp_stall);
      int stall_n;
      int w;
      req_t r;
      res_t e;
      #1;
      chk("issue_stall", 64'(memory_o_stall), 64'd1);
      chk("issue_req_valid", 64'(bus.dmem_req_valid), 64'd0);
      stall_n = memory_o_stall ? 1 : 0;
      for (int k = 0; k <= ready_delay; k++) begin
         @(negedge clk);
         bus.dmem_req_ready = (k == ready_delay);
         #1;
         if (memory_o_stall) stall_n++;
         chk("req_valid", 64'(bus.dmem_req_valid), 64'd1);
         if (req_q.size() > 0) chk("req_addr", bus.dmem_req_addr, req_q[0].addr);
         if (k == ready_delay && req_q.size() > 0) begin
            r = req_q.pop_front();
            chk("req_wen", 64'(bus.dmem_req_wen), 64'(r.wen));
            chk("req_wdata", bus.dmem_req_wdata, r.wdata);
            chk("req_wstrb", 64'(bus.dmem_req_wstrb), 64'(r.wstrb));
         end
      end
      @(negedge clk);
      bus.dmem_req_ready = 1'b0;
      for (w = 0; w < 40; w++) begin
         bus.dmem_resp_valid = respond && (w == resp_delay - 1);
         bus.dmem_resp_rdata = rdata;
         #1;
         if (!memory_o_stall) break;
         stall_n++;
         @(negedge clk);
      end
      bus.dmem_resp_valid = 1'b0;
      regM_i_valid = 1'b0;
      chk("done_reached", 64'(w < 40), 64'd1);
      chk("stall_cycles", 64'(stall_n), 64'(exp_stall));
      e = res_q.pop_front();
      chk("memdata", memory_o_memdata, e.memdata);
      chk("bus_err", 64'(memory_o_bus_err), 64'(e.bus_err));
      @(negedge clk);
      #1;
      chk("post_bus_err", 64'(memory_o_bus_err), 64'd0);
      chk("post_stall", 64'(memory_o_stall), 64'd0);
      chk("post_memdata", memory_o_memdata, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      rst = 1'b0;
      regM_i_valid = 1'b0; regM_i_mem_ren = 1'b0; regM_i_mem_wen = 1'b0;
      regM_i_mem_size = 2'd0; regM_i_mem_unsigned = 1'b0;
      regM_i_alu_result = 64'd0; regM_i_store_data = 64'd0;
      bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_resp_rdata = 64'd0;

      // Outputs stay quiet while reset is held, even with live ops presented.
      @(negedge clk);
      issue(1, 0, 2'd3, 0, 64'h1000, 64'd0);
      #1;
      chk("rst_stall", 64'(memory_o_stall), 64'd0);
      chk("rst_req_valid", 64'(bus.dmem_req_valid), 64'd0);
      chk("rst_memdata", memory_o_memdata, 64'd0);
      chk("rst_bus_err", 64'(memory_o_bus_err), 64'd0);
      @(negedge clk);
      issue(1, 0, 2'd2, 0, 64'h3002, 64'd0);
      #1;
      chk("rst_misalign", 64'(memory_o_misalign), 64'd0);
      @(negedge clk);
      regM_i_valid = 1'b0;
      rst = 1'b1;

      // lb / lbu from lane 3
      @(negedge clk);
      issue(1, 0, 2'd0, 0, 64'h1003, 64'd0);
      push_req(64'h1000, 1'b0, 64'd0, 8'h00);
      push_res(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      run_op(0, 1, 1, 64'h0000_0000_8000_0000, 3);

      @(negedge clk);
      issue(1, 0, 2'd0, 1, 64'h1003, 64'd0);
      push_req(64'h1000, 1'b0, 64'd0, 8'h00);
      push_res(64'h80, 1'b0);
      run_op(0, 1, 1, 64'h0000_0000_8000_0000, 3);

      // sh into the top half-word
      @(negedge clk);
      issue(0, 1, 2'd1, 0, 64'h2006, 64'h1234);
      push_req(64'h2000, 1'b1, 64'h1234_0000_0000_0000, 8'hC0);
      push_res(64'd0, 1'b0);
      run_op(0, 1, 1, 64'hDEAD_BEEF_DEAD_BEEF, 3);

      // Misaligned lw: one-cycle pulse, no request
      @(negedge clk);
      issue(1, 0, 2'd2, 0, 64'h3002, 64'd0);
      #1;
      chk("mis_pulse", 64'(memory_o_misalign), 64'd1);
      chk("mis_stall", 64'(memory_o_stall), 64'd0);
      chk("mis_req_valid", 64'(bus.dmem_req_valid), 64'd0);
      chk("mis_memdata", memory_o_memdata, 64'd0);
      @(negedge clk);
      regM_i_valid = 1'b0;
      #1;
      chk("mis_pulse_end", 64'(memory_o_misalign), 64'd0);
      chk("mis_req_valid2", 64'(bus.dmem_req_valid), 64'd0);

      // Misaligned sd at offset 4
      @(negedge clk);
      issue(0, 1, 2'd3, 0, 64'h3004, 64'h55);
      #1;
      chk("mis_sd_pulse", 64'(memory_o_misalign), 64'd1);
      chk("mis_sd_stall", 64'(memory_o_stall), 64'd0);
      @(negedge clk);
      regM_i_valid = 1'b0;

      // ld, ready low 5 cycles, response 3 cycles after handshake
      @(negedge clk);
      issue(1, 0, 2'd3, 0, 64'h4008, 64'd0);
      push_req(64'h4008, 1'b0, 64'd0, 8'h00);
      push_res(64'h0123_4567_89AB_CDEF, 1'b0);
      run_op(5, 3, 1, 64'h0123_4567_89AB_CDEF, 10);

      // lh / lw / lwu checked against the reference load
      rd = 64'h8899_AABB_CCDD_EEFF;
      @(negedge clk);
      issue(1, 0, 2'd1, 0, 64'h500A, 64'd0);
      push_req(64'h5008, 1'b0, 64'd0, 8'h00);
      push_res(load_model(2'd1, 0, 2, rd), 1'b0);
      run_op(1, 2, 1, rd, 5);

      @(negedge clk);
      issue(1, 0, 2'd2, 0, 64'h5004, 64'd0);
      push_req(64'h5000, 1'b0, 64'd0, 8'h00);
      push_res(load_model(2'd2, 0, 4, rd), 1'b0);
      run_op(0, 1, 1, rd, 3);

      @(negedge clk);
      issue(1, 0, 2'd2, 1, 64'h5004, 64'd0);
      push_req(64'h5000, 1'b0, 64'd0, 8'h00);
      push_res(load_model(2'd2, 1, 4, rd), 1'b0);
      run_op(0, 1, 1, rd, 3);

      // sw upper word, sb top byte with store data truncated
      @(negedge clk);
      issue(0, 1, 2'd2, 0, 64'h6004, 64'hCAFE_BABE);
      push_req(64'h6000, 1'b1, 64'hCAFE_BABE_0000_0000, 8'hF0);
      push_res(64'd0, 1'b0);
      run_op(2, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5);

      @(negedge clk);
      issue(0, 1, 2'd0, 0, 64'h7007, 64'hFFFF_FFFF_FFFF_FFAB);
      push_req(64'h7000, 1'b1, 64'hAB00_0000_0000_0000, 8'h80);
      push_res(64'd0, 1'b0);
      run_op(0, 2, 1, 64'd0, 4);

      // Timeout (TIMEOUT=4): error pulse, zero data, late response ignored
      @(negedge clk);
      issue(1, 0, 2'd3, 0, 64'h8000, 64'd0);
      push_req(64'h8000, 1'b0, 64'd0, 8'h00);
      push_res(64'd0, 1'b1);
      run_op(0, 0, 0, 64'h1111_2222_3333_4444, 6);
      @(negedge clk);
      bus.dmem_resp_valid = 1'b1;
      bus.dmem_resp_rdata = 64'h1111_2222_3333_4444;
      #1;
      chk("late_resp_stall", 64'(memory_o_stall), 64'd0);
      chk("late_resp_memdata", memory_o_memdata, 64'd0);
      @(negedge clk);
      bus.dmem_resp_valid = 1'b0;
      #1;
      chk("late_resp_memdata2", memory_o_memdata, 64'd0);
      chk("late_resp_bus_err", 64'(memory_o_bus_err), 64'd0);

      // Reset while waiting for a response
      @(negedge clk);
      issue(1, 0, 2'd3, 0, 64'h9000, 64'd0);
      #1;
      chk("abort_issue_stall", 64'(memory_o_stall), 64'd1);
      @(negedge clk);
      bus.dmem_req_ready = 1'b1;
      #1;
      chk("abort_req_valid", 64'(bus.dmem_req_valid), 64'd1);
      @(negedge clk);
      bus.dmem_req_ready = 1'b0;
      #1;
      chk("abort_wait_stall", 64'(memory_o_stall), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_rst_stall", 64'(memory_o_stall), 64'd0);
      chk("abort_rst_req_valid", 64'(bus.dmem_req_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      regM_i_valid = 1'b0;
      #1;
      chk("abort_idle_stall", 64'(memory_o_stall), 64'd0);
      chk("abort_idle_req_valid", 64'(bus.dmem_req_valid), 64'd0);
      @(negedge clk);
      bus.dmem_resp_valid = 1'b1;
      bus.dmem_resp_rdata = 64'hFEED_FACE_FEED_FACE;
      #1;
      chk("stale_resp_stall", 64'(memory_o_stall), 64'd0);
      chk("stale_resp_memdata", memory_o_memdata, 64'd0);
      @(negedge clk);
      bus.dmem_resp_valid = 1'b0;
      #1;
      chk("stale_resp_memdata2", memory_o_memdata, 64'd0);

      // Normal operation resumes after the abort
      @(negedge clk);
      issue(1, 0, 2'd3, 0, 64'hA010, 64'd0);
      push_req(64'hA010, 1'b0, 64'd0, 8'h00);
      push_res(64'h0F0E_0D0C_0B0A_0908, 1'b0);
      run_op(1, 2, 1, 64'h0F0E_0D0C_0B0A_0908, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
